fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It supports a variable-latency memory, a single-entry output buffer towards decode, and redirects from execute (taken branches and jumps). Redirects that arrive while a request is in flight are handled by killing the in-flight response. It sits between the instruction memory and the decode stage and replaces the free-running PC increment with a handshake-aware next-PC selection.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1: memory response; qualifies `imem_rdata`; sampled only when `imem_req` is high.
- `imem_rdata`  in  32: fetched instruction word.
- `if_valid`  out  1: output buffer holds an instruction for decode.
- `if_instr`  out  32: buffered instruction.
- `if_pc`  out  32: address of `if_instr`.
- `id_ready`  in  1: decode accepts the buffer this cycle (transfer when `if_valid && id_ready`).
- `redirect`  in  1: one-cycle pulse from execute; load a new PC and flush.
- `redirect_target`  in  32: new PC, qualified by `redirect`.
- `fetch_err`  out  1: sticky misaligned-redirect flag (see Configuration).

## Operation
- States: RUN (no request outstanding), WAIT (request issued, no ack yet), KILL (outstanding request whose data will be discarded), HALT (error stop).
- Reset values: state=RUN, pc=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `fetch_err`=0, `imem_req`=0 while reset is asserted.
- RUN:
  - `imem_req` = buffer free, where free = `!if_valid || id_ready`.
  - `imem_addr` = pc. The issued address is captured into `req_addr`.
  - Req and ack in the same cycle: load the buffer (`if_instr`=rdata, `if_pc`=pc); pc <= pc+4; stay in RUN.
  - Req without ack: go to WAIT.
- WAIT:
  - `imem_req`=1 and `imem_addr`=`req_addr` until ack. The request is never withdrawn.
  - The buffer is empty in this state by construction.
  - On ack: load the buffer, pc <= `req_addr`+4, go to RUN.
- Buffer consumption: `if_valid && id_ready` with no load in that cycle clears `if_valid`.
- Redirect has priority over every other event:
  - Effects: pc <= target; `if_valid` <= 0; any ack in the same cycle is discarded.
  - If a request remains outstanding afterwards (RUN with req && !ack, or WAIT without ack), go to KILL. Otherwise go to RUN.
- KILL:
  - `imem_req`=1 at `req_addr` until ack; the returned data is dropped.
  - On ack, go to RUN and issue from the redirected pc.
  - A further redirect in KILL updates pc and stays in KILL.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- No buffer load ever occurs while `redirect` is high.
- Asynchronous reset mid-request abandons the request. The memory must tolerate `imem_req` dropping without an ack.

## Timing
- First request: `imem_req` is high in the first cycle after reset deasserts, at `RESET_PC`.
- With a zero-wait memory (ack in the request cycle), `if_valid` rises at the next edge. Sustained throughput is 1 instruction/cycle with `id_ready` held high.
- With an N-cycle ack delay, the instruction appears at edge N+1 after the request is raised.
- Redirect latency: a request to the target is issued the cycle after `redirect` when idle. When killing, it is issued the cycle after the killed ack.
- `imem_req` and `imem_addr` are combinational from state, `if_valid` and `id_ready`. All other outputs are registered.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_target[1:0]` != 0 still flushes and kills, but pc is not loaded.
  - `fetch_err` sets (sticky).
  - After any outstanding request drains, the state becomes HALT: no requests and `if_valid`=0 until reset.
- Not defined: `redirect_target[1:0]` is ignored (forced to 00), `fetch_err` is tied 0, and HALT is unreachable.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {RUN, WAIT, KILL, HALT}.
  - `XLEN`=32.
  - `INSTR_BYTES`=4.
- Sub-module `fetch_buf`: single-entry output register with load, consume and flush inputs. It holds `if_valid`, `if_instr` and `if_pc`.

## Test plan
- Reset, zero-wait memory returning `imem_rdata`=addr, `id_ready`=1 -> `if_pc` sequence 0,4,8,C on consecutive cycles; `if_instr`==`if_pc`.
- Ack delayed 3 cycles -> `imem_addr` stable for 4 cycles, `if_valid` high 1 cycle after ack, next request at addr+4.
- `id_ready`=0 for 5 cycles with a full buffer -> `imem_req`=0, `if_instr` held; raising `id_ready` -> transfer and a new request in the same cycle.
- Redirect to 32'h100 while WAIT at addr 8 -> KILL, the addr-8 data is never presented, next `if_pc`=32'h100.
- Redirect coinciding with ack -> data dropped, `if_valid`=0, next request at the target; pc at 32'hFFFF_FFFC wraps to 0.
- With `FETCH_MISALIGN_TRAP_EN`, redirect to 32'h102 -> `fetch_err`=1, HALT, no further `imem_req` until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    KILL,
    HALT
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory, decode and redirect signals of the fetch sequencer.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            fetch_err;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_err,
    input  imem_ack, imem_rdata, id_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_err,
    output imem_ack, imem_rdata, id_ready, redirect, redirect_target
  );

endinterface

// File: rtl/fetch_buf.sv
// Single-entry output register towards decode; flush wins over load, load over consume.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         consume,
  input  logic         flush,
  input  fetch_entry_t load_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC ownership, imem handshake, redirect/kill handling.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] addr;
  logic            err;
  logic            err_next;
  logic            misalign;
  logic            req;
  logic            ack;
  logic            outstanding;
  logic            free;
  logic            load;
  logic            consume;
  logic            buf_valid;
  fetch_entry_t    buf_entry;
  fetch_entry_t    load_entry;

  assign free = !buf_valid || bus.id_ready;

  // Request is combinational so a freed buffer can be refilled in the same cycle.
  always_comb begin
    req  = 1'b0;
    addr = pc;
    case (state)
      RUN:  req = free;
      WAIT,
      KILL: begin
        req  = 1'b1;
        addr = req_addr;
      end
      HALT: req = 1'b0;
    endcase
    req = req && reset;
  end

  assign ack         = req && bus.imem_ack;
  assign outstanding = req && !bus.imem_ack;
  assign redir_pc    = bus.redirect_target & ~XLEN'(INSTR_BYTES - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = bus.redirect && (|bus.redirect_target[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign err_next   = err || misalign;
  assign load       = ack && !bus.redirect && (state == RUN || state == WAIT);
  assign consume    = buf_valid && bus.id_ready;
  assign load_entry = '{pc: addr, instr: bus.imem_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      err      <= 1'b0;
    end else begin
      if (state == RUN && req) begin
        req_addr <= pc;
      end
      // Redirect overrides everything; an unacked request must still drain in KILL.
      if (bus.redirect && state != HALT) begin
        if (!misalign) begin
          pc <= redir_pc;
        end
        err <= err_next;
        if (outstanding) begin
          state <= KILL;
        end else begin
          state <= err_next ? HALT : RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (ack) begin
              pc <= next_pc(pc);
            end else if (req) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (ack) begin
              pc    <= next_pc(req_addr);
              state <= RUN;
            end
          end
          KILL: begin
            if (ack) begin
              state <= err ? HALT : RUN;
            end
          end
          HALT: state <= HALT;
        endcase
      end
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .consume    (consume),
    .flush      (bus.redirect),
    .load_entry (load_entry),
    .valid      (buf_valid),
    .entry      (buf_entry)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.if_valid  = buf_valid;
  assign bus.if_instr  = buf_entry.instr;
  assign bus.if_pc     = buf_entry.pc;
  assign bus.fetch_err = err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a program-order reference model and a variable-latency memory model.
module tb_fetch_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory model
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          lat_lo, lat_hi;
  bit          slow_en;
  logic [31:0] slow_addr;
  int          slow_lat;

  // reference model: next address decode must see, in program order
  logic [31:0] exp_pc;
  bit          halted;
  bit          was_redir;
  int          idle_cycles;
  int          n_deliv;

  logic [31:0] obs_req, obs_addr, obs_ack, obs_valid, obs_pc, obs_instr, obs_err;

  // One clock cycle: drive at entry (just after negedge), sample/respond 1ns later, end at next negedge.
  task automatic cyc(input bit rdy, input bit rdr, input logic [31:0] tgt);
    bus.id_ready        = rdy;
    bus.redirect        = rdr;
    bus.redirect_target = tgt;
    #1;
    obs_req   = 32'(bus.imem_req);
    obs_addr  = bus.imem_addr;
    obs_valid = 32'(bus.if_valid);
    obs_pc    = bus.if_pc;
    obs_instr = bus.if_instr;
    obs_err   = 32'(bus.fetch_err);

    if (mem_pend) chk("req_hold", obs_req, 32'd1);
    if (obs_req != 0) begin
      if (!mem_pend) begin
        if (halted) chk("halt_req", obs_req, 32'd0);
        mem_pend = 1'b1;
        mem_addr = obs_addr;
        mem_wait = (slow_en && obs_addr == slow_addr) ? slow_lat : int'($urandom_range(lat_hi, lat_lo));
      end else begin
        chk("addr_stable", obs_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(mem_addr);
        mem_pend       = 1'b0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        mem_wait--;
      end
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
    end
    obs_ack = 32'(bus.imem_ack);

    if (was_redir) chk("flush", obs_valid, 32'd0);
    if (halted) chk("halt_valid", obs_valid, 32'd0);
    if (obs_valid != 0) begin
      chk("if_pc", obs_pc, exp_pc);
      chk("if_instr", obs_instr, mem_word(obs_pc));
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fetch_err", obs_err, 32'(halted));
`else
    chk("fetch_err", obs_err, 32'd0);
`endif
    if (obs_valid != 0 && rdy) begin
      exp_pc      = exp_pc + 32'd4;
      idle_cycles = 0;
      n_deliv++;
    end else begin
      idle_cycles++;
    end
    was_redir = rdr;
    if (rdr) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) halted = 1'b1;
      else exp_pc = tgt;
`else
      exp_pc = tgt & ~32'h3;
`endif
    end
    if (idle_cycles > 300 && !halted) begin
      chk("progress", 32'(idle_cycles), 32'd0);
      idle_cycles = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset               = 1'b0;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = '0;
    bus.id_ready        = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_err", 32'(bus.fetch_err), 32'd0);
    mem_pend    = 1'b0;
    mem_wait    = 0;
    exp_pc      = 32'h0;
    halted      = 1'b0;
    was_redir   = 1'b0;
    idle_cycles = 0;
    reset       = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit          found;
    bit          prev_ack;
    bit          rdy, rdr;
    logic [31:0] tgt;

    slow_en = 1'b0; slow_addr = '0; slow_lat = 0;
    n_deliv = 0;
    @(negedge clk);

    // zero-wait memory, decode always ready
    lat_lo = 0; lat_hi = 0;
    do_reset();
    cyc(1'b1, 1'b0, '0);
    chk("t1_req", obs_req, 32'd1);
    chk("t1_addr", obs_addr, 32'h0);
    chk("t1_valid0", obs_valid, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("t1_valid", obs_valid, 32'd1);
      chk("t1_pc", obs_pc, 32'(i * 4));
      chk("t1_addr_next", obs_addr, 32'(i * 4 + 4));
    end

    // three-cycle ack delay
    lat_lo = 3; lat_hi = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("t2_req", obs_req, 32'd1);
      chk("t2_addr", obs_addr, 32'h0);
      chk("t2_valid", obs_valid, 32'd0);
      chk("t2_ack", obs_ack, 32'(i == 3));
    end
    cyc(1'b1, 1'b0, '0);
    chk("t2_valid_after", obs_valid, 32'd1);
    chk("t2_pc_after", obs_pc, 32'h0);
    chk("t2_next_addr", obs_addr, 32'h4);

    // decode stall with a full buffer
    lat_lo = 0; lat_hi = 0;
    do_reset();
    cyc(1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, '0);
      chk("t3_req", obs_req, 32'd0);
      chk("t3_valid", obs_valid, 32'd1);
      chk("t3_instr", obs_instr, mem_word(32'h0));
    end
    cyc(1'b1, 1'b0, '0);
    chk("t3_req_release", obs_req, 32'd1);
    chk("t3_addr_release", obs_addr, 32'h4);
    cyc(1'b1, 1'b0, '0);
    chk("t3_pc_next", obs_pc, 32'h4);

    // redirect while waiting on address 8
    slow_en = 1'b1; slow_addr = 32'h8; slow_lat = 5;
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, '0);
    chk("t4_wait_addr", obs_addr, 32'h8);
    chk("t4_wait_ack", obs_ack, 32'd0);
    cyc(1'b1, 1'b1, 32'h100);
    found = 1'b0;
    prev_ack = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (obs_req != 0 && obs_addr == 32'h100) begin
        found = 1'b1;
        chk("t4_issue_after_kill", 32'(prev_ack), 32'd1);
      end else begin
        chk("t4_kill_valid", obs_valid, 32'd0);
        prev_ack = obs_ack[0];
      end
    end
    chk("t4_found", 32'(found), 32'd1);
    cyc(1'b1, 1'b0, '0);
    chk("t4_pc", obs_pc, 32'h100);
    chk("t4_valid", obs_valid, 32'd1);
    slow_en = 1'b0;

    // redirect coinciding with ack, then wrap past the top of memory
    do_reset();
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("t5_ack", obs_ack, 32'd1);
    cyc(1'b1, 1'b0, '0);
    chk("t5_dropped", obs_valid, 32'd0);
    chk("t5_addr", obs_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, '0);
    chk("t5_pc_top", obs_pc, 32'hFFFF_FFFC);
    chk("t5_addr_wrap", obs_addr, 32'h0);
    cyc(1'b1, 1'b0, '0);
    chk("t5_pc_wrap", obs_pc, 32'h0);

    // misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
    lat_lo = 2; lat_hi = 2;
    do_reset();
    cyc(1'b1, 1'b1, 32'h102);
    cyc(1'b1, 1'b0, '0);
    chk("t6_err", obs_err, 32'd1);
    chk("t6_drain_req", obs_req, 32'd1);
    chk("t6_drain_addr", obs_addr, 32'h0);
    cyc(1'b1, 1'b0, '0);
    chk("t6_drain_ack", obs_ack, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("t6_halt_req", obs_req, 32'd0);
      chk("t6_halt_valid", obs_valid, 32'd0);
    end
    lat_lo = 0; lat_hi = 0;
    do_reset();
    cyc(1'b1, 1'b0, '0);
    chk("t6_restart", obs_req, 32'd1);
`else
    lat_lo = 0; lat_hi = 0;
    do_reset();
    cyc(1'b1, 1'b1, 32'h102);
    cyc(1'b1, 1'b0, '0);
    chk("t6_addr_aligned", obs_addr, 32'h100);
    chk("t6_valid", obs_valid, 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("t6_pc_aligned", obs_pc, 32'h100);
`endif

    // randomized traffic
    lat_lo = 0; lat_hi = 3;
    do_reset();
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(3, 0) != 0);
      rdr = ($urandom_range(9, 0) == 0);
      if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
      else tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt[1:0] = 2'b00;
`endif
      cyc(rdy, rdr, tgt);
    end
    chk("rnd_deliveries", 32'(n_deliv > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
